mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 167 ++++++++++++++++
 tb/tb_mem_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage. ALU results pass straight through with one
// cycle of latency; loads and stores wait in WAIT for a one-cycle dmem_ack.
// A watchdog abandons the access after TIMEOUT WAIT cycles and pulses mem_err.
module mem_stage #(
    parameter int ARQ     = 16,
    parameter int TIMEOUT = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wb_enable_in,
    input  logic           pc_en_in,
    input  logic           rd_mem_en,
    input  logic           wr_mem_en,
    input  logic [ARQ-1:0] src1_in,
    input  logic [ARQ-1:0] srcdest_in,
    input  logic [ARQ-1:0] alu_result_in,
    output logic           stall,
    output logic           dmem_req,
    output logic           dmem_we,
    output logic [ARQ-1:0] dmem_addr,
    output logic [ARQ-1:0] dmem_wdata,
    input  logic [ARQ-1:0] dmem_rdata,
    input  logic           dmem_ack,
    output logic           wb_enable_out,
    output logic           pc_en_out,
    output logic [ARQ-1:0] srcdest_out,
    output logic [ARQ-1:0] wb_data_out,
    output logic           mem_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_e         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;

    // Fields captured when a memory op is accepted from EX/MEM.
    logic           store_q, store_d;
    logic [ARQ-1:0] addr_q, addr_d;
    logic [ARQ-1:0] wdata_q, wdata_d;
    logic [ARQ-1:0] dest_q, dest_d;
    logic           wb_en_q, wb_en_d;
    logic           pc_en_q, pc_en_d;

    // MEM/WB output register.
    logic           wb_out_q, wb_out_d;
    logic           pc_out_q, pc_out_d;
    logic [ARQ-1:0] dest_out_q, dest_out_d;
    logic [ARQ-1:0] data_out_q, data_out_d;
    logic           err_q, err_d;

    // Next-state, memory interface and MEM/WB load values for the current cycle.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case
        // leaves it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        store_d    = store_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        dest_d     = dest_q;
        wb_en_d    = wb_en_q;
        pc_en_d    = pc_en_q;
        stall      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        // Bubble unless a branch below loads real writeback data.
        wb_out_d   = 1'b0;
        pc_out_d   = 1'b0;
        dest_out_d = '0;
        data_out_d = '0;
        err_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (rd_mem_en || wr_mem_en) begin
                    stall   = 1'b1;
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    store_d = wr_mem_en;  // rd+wr together behaves as a store
                    addr_d  = alu_result_in;
                    wdata_d = src1_in;
                    dest_d  = srcdest_in;
                    wb_en_d = wb_enable_in;
                    pc_en_d = pc_en_in;
                end else begin
                    wb_out_d   = wb_enable_in;
                    pc_out_d   = pc_en_in;
                    dest_out_d = srcdest_in;
                    data_out_d = alu_result_in;
                end
            end
            S_WAIT: begin
                dmem_req   = 1'b1;
                dmem_we    = store_q;
                dmem_addr  = addr_q;
                dmem_wdata = wdata_q;
                if (dmem_ack) begin
                    state_d    = S_IDLE;
                    wb_out_d   = wb_en_q;
                    pc_out_d   = pc_en_q;
                    dest_out_d = dest_q;
                    data_out_d = store_q ? addr_q : dmem_rdata;
                end else if (cnt_q == LAST_WAIT) begin
                    // Abort: keep the destination for diagnosis, suppress writeback.
                    state_d    = S_IDLE;
                    dest_out_d = dest_q;
                    err_d      = 1'b1;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, captured-op and MEM/WB registers; reset wins over ack and timeout.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the captured-op registers are reset too; they are few flops
            // and keeping them clean makes post-reset dmem_* values deterministic.
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            store_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            dest_q     <= '0;
            wb_en_q    <= 1'b0;
            pc_en_q    <= 1'b0;
            wb_out_q   <= 1'b0;
            pc_out_q   <= 1'b0;
            dest_out_q <= '0;
            data_out_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            store_q    <= store_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            dest_q     <= dest_d;
            wb_en_q    <= wb_en_d;
            pc_en_q    <= pc_en_d;
            wb_out_q   <= wb_out_d;
            pc_out_q   <= pc_out_d;
            dest_out_q <= dest_out_d;
            data_out_q <= data_out_d;
            err_q      <= err_d;
        end
    end

    assign wb_enable_out = wb_out_q;
    assign pc_en_out     = pc_out_q;
    assign srcdest_out   = dest_out_q;
    assign wb_data_out   = data_out_q;
    assign mem_err       = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: transaction-level checking of mem_stage. Each transaction
// (ALU op, load, store, reset mid-access) is expanded into the cycle-by-cycle
// outputs that the stage's rules predict, from a directed table and then at random.
module tb_mem_stage;

    localparam int ARQ     = 16;
    localparam int TIMEOUT = 8;
    localparam int NO_ACK  = 1000;

    localparam int K_ALU   = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;
    localparam int K_BOTH  = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           wb_enable_in, pc_en_in, rd_mem_en, wr_mem_en;
    logic [ARQ-1:0] src1_in, srcdest_in, alu_result_in;
    logic           stall, dmem_req, dmem_we;
    logic [ARQ-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic           dmem_ack;
    logic           wb_enable_out, pc_en_out;
    logic [ARQ-1:0] srcdest_out, wb_data_out;
    logic           mem_err;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage #(.ARQ(ARQ), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_enable_in  (wb_enable_in),
        .pc_en_in      (pc_en_in),
        .rd_mem_en     (rd_mem_en),
        .wr_mem_en     (wr_mem_en),
        .src1_in       (src1_in),
        .srcdest_in    (srcdest_in),
        .alu_result_in (alu_result_in),
        .stall         (stall),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_ack      (dmem_ack),
        .wb_enable_out (wb_enable_out),
        .pc_en_out     (pc_en_out),
        .srcdest_out   (srcdest_out),
        .wb_data_out   (wb_data_out),
        .mem_err       (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             kind;
        logic [ARQ-1:0] alu;     // ALU result or memory address
        logic [ARQ-1:0] src1;
        logic [ARQ-1:0] dest;
        logic           wb;
        logic           pc;
        int             delay;   // WAIT cycle index carrying ack; >= TIMEOUT means none
        logic [ARQ-1:0] rdata;
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic r, input logic wb, input logic pc, input logic rd,
                         input logic wr, input logic [ARQ-1:0] s1, input logic [ARQ-1:0] sd,
                         input logic [ARQ-1:0] alu, input logic ack, input logic [ARQ-1:0] rdat);
        rst = r; wb_enable_in = wb; pc_en_in = pc; rd_mem_en = rd; wr_mem_en = wr;
        src1_in = s1; srcdest_in = sd; alu_result_in = alu; dmem_ack = ack; dmem_rdata = rdat;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_comb(input string tag, input logic st, input logic req, input logic we,
                            input logic [ARQ-1:0] a, input logic [ARQ-1:0] w);
        check({tag, ".stall"}, 32'(stall), 32'(st));
        check({tag, ".req"},   32'(dmem_req), 32'(req));
        check({tag, ".we"},    32'(dmem_we), 32'(we));
        check({tag, ".addr"},  32'(dmem_addr), 32'(a));
        check({tag, ".wdata"}, 32'(dmem_wdata), 32'(w));
    endtask

    task automatic chk_regs(input string tag, input logic wb, input logic pc,
                            input logic [ARQ-1:0] sd, input logic [ARQ-1:0] data, input logic err);
        check({tag, ".wb_en"},  32'(wb_enable_out), 32'(wb));
        check({tag, ".pc_en"},  32'(pc_en_out), 32'(pc));
        check({tag, ".dest"},   32'(srcdest_out), 32'(sd));
        check({tag, ".wbdata"}, 32'(wb_data_out), 32'(data));
        check({tag, ".err"},    32'(mem_err), 32'(err));
    endtask

    // Non-memory op in IDLE: one-cycle passthrough, ack (possibly spurious) ignored.
    task automatic alu_txn(input string tag, input logic [ARQ-1:0] alu, input logic [ARQ-1:0] sd,
                           input logic wb, input logic pc, input logic ack);
        drive(1'b0, wb, pc, 1'b0, 1'b0, 16'($urandom), sd, alu, ack, 16'($urandom));
        #2;
        chk_comb(tag, 1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        chk_regs(tag, wb, pc, sd, alu, 1'b0);
    endtask

    // Load/store: one IDLE stall cycle, then WAIT cycles until ack or timeout.
    // EX/MEM inputs are scrambled during WAIT to prove the op was captured.
    task automatic mem_txn(input string tag, input logic rd, input logic wr,
                           input logic [ARQ-1:0] addr, input logic [ARQ-1:0] s1,
                           input logic [ARQ-1:0] sd, input logic wb, input logic pc,
                           input int delay, input logic [ARQ-1:0] rdat,
                           output int stall_n, output int req_n);
        logic store, ack, last;
        store   = wr;
        stall_n = 0;
        req_n   = 0;
        drive(1'b0, wb, pc, rd, wr, s1, sd, addr, 1'b0, 16'($urandom));
        #2;
        chk_comb({tag, ".idle"}, 1'b1, 1'b0, 1'b0, '0, '0);
        if (stall) stall_n++;
        tick();
        chk_regs({tag, ".idle"}, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int k = 0; k < TIMEOUT; k++) begin
            ack  = (k == delay);
            last = (k == TIMEOUT - 1);
            drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  16'($urandom), 16'($urandom), 16'($urandom), ack, ack ? rdat : 16'($urandom));
            #2;
            chk_comb({tag, ".wait"}, !(ack || last), 1'b1, store, addr, s1);
            if (stall) stall_n++;
            if (dmem_req) req_n++;
            tick();
            if (ack) begin
                chk_regs({tag, ".ack"}, wb, pc, sd, store ? addr : rdat, 1'b0);
                break;
            end else if (last) begin
                chk_regs({tag, ".tmo"}, 1'b0, 1'b0, sd, '0, 1'b1);
                break;
            end else begin
                chk_regs({tag, ".wait"}, 1'b0, 1'b0, '0, '0, 1'b0);
            end
        end
    endtask

    // Start a load, then assert rst (optionally with ack) in WAIT cycle `at`;
    // the access must vanish without writeback or mem_err.
    task automatic reset_in_wait(input string tag, input int at, input logic ack);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h1111, 16'h0007, 16'h0020, 1'b0, '0);
        tick();
        for (int k = 0; k < at; k++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
            tick();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, 16'h0009, 16'h0099, ack, 16'hBEEF);
        #2;
        check({tag, ".req_before"}, 32'(dmem_req), 32'd1);
        tick();
        chk_regs({tag, ".rst"}, 1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 16'h000A, 16'h0ABC, 1'b1, 16'hBEEF);
        #2;
        chk_comb({tag, ".after"}, 1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        chk_regs({tag, ".after"}, 1'b1, 1'b0, 16'h000A, 16'h0ABC, 1'b0);
    endtask

    // Hard time limit so the run can never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[8];
        int   sn, rn, exp_n, kind, dly;
        logic rd, wr;

        vecs[0] = '{K_ALU,   16'h1234, 16'h0000, 16'h0003, 1'b1, 1'b0, 0,      16'h0000};
        vecs[1] = '{K_LOAD,  16'h0040, 16'h0000, 16'h0004, 1'b1, 1'b1, 2,      16'hBEEF};
        vecs[2] = '{K_BOTH,  16'h0010, 16'hA5A5, 16'h0002, 1'b1, 1'b0, 3,      16'h7777};
        vecs[3] = '{K_LOAD,  16'h0050, 16'h0000, 16'h0005, 1'b1, 1'b1, NO_ACK, 16'h0000};
        vecs[4] = '{K_STORE, 16'hFFFF, 16'h0001, 16'h0006, 1'b0, 1'b1, 0,      16'h3333};
        vecs[5] = '{K_LOAD,  16'h0060, 16'h0000, 16'h0008, 1'b1, 1'b0, TIMEOUT - 1, 16'h55AA};
        vecs[6] = '{K_ALU,   16'hFFFF, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 0,      16'h0000};
        vecs[7] = '{K_ALU,   16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 0,      16'h0000};

        // Reset with a memory request pending at the inputs.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF);
        tick();
        tick();
        chk_regs("reset", 1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
        #2;
        chk_comb("reset", 1'b0, 1'b0, 1'b0, '0, '0);
        tick();

        // Directed table.
        foreach (vecs[i]) begin
            if (vecs[i].kind == K_ALU) begin
                alu_txn($sformatf("vec%0d", i), vecs[i].alu, vecs[i].dest, vecs[i].wb, vecs[i].pc, 1'b1);
            end else begin
                rd = (vecs[i].kind == K_LOAD) || (vecs[i].kind == K_BOTH);
                wr = (vecs[i].kind == K_STORE) || (vecs[i].kind == K_BOTH);
                mem_txn($sformatf("vec%0d", i), rd, wr, vecs[i].alu, vecs[i].src1, vecs[i].dest,
                        vecs[i].wb, vecs[i].pc, vecs[i].delay, vecs[i].rdata, sn, rn);
                exp_n = (vecs[i].delay < TIMEOUT) ? vecs[i].delay + 1 : TIMEOUT;
                check($sformatf("vec%0d.stall_cycles", i), 32'(sn), 32'(exp_n));
                check($sformatf("vec%0d.req_cycles", i), 32'(rn), 32'(exp_n));
            end
        end
        // mem_err must drop after the timeout pulse.
        alu_txn("post_tmo", 16'h0101, 16'h0001, 1'b1, 1'b1, 1'b0);

        // Reset mid-access: with ack in the 2nd WAIT cycle, and on the timeout cycle.
        reset_in_wait("rst_ack", 1, 1'b1);
        reset_in_wait("rst_tmo", TIMEOUT - 1, 1'b0);

        // Random transactions.
        for (int t = 0; t < 200; t++) begin
            kind = $urandom_range(0, 4);
            dly  = $urandom_range(0, TIMEOUT + 1);
            case (kind)
                0: alu_txn($sformatf("rnd%0d", t), 16'($urandom), 16'($urandom),
                           1'($urandom), 1'($urandom), 1'($urandom));
                4: reset_in_wait($sformatf("rnd%0d", t), $urandom_range(0, TIMEOUT - 1), 1'($urandom));
                default: begin
                    rd = (kind != 2);
                    wr = (kind != 1);
                    mem_txn($sformatf("rnd%0d", t), rd, wr, 16'($urandom), 16'($urandom),
                            16'($urandom), 1'($urandom), 1'($urandom), dly, 16'($urandom), sn, rn);
                    exp_n = (dly < TIMEOUT) ? dly + 1 : TIMEOUT;
                    check($sformatf("rnd%0d.req_cycles", t), 32'(rn), 32'(exp_n));
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
